// File: rtl/ibex_fetch_realign_fifo_pkg.sv
// Shared types and helpers for the fetch realignment FIFO.
package ibex_fetch_realign_fifo_pkg;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } fetch_entry_t;

   function automatic logic is_compressed(input logic [1:0] lsb);
      return lsb != 2'b11;
   endfunction

endpackage

// File: rtl/ibex_fetch_realign_fifo_if.sv
// Fetch-word input and realigned-instruction output bundle of the fetch FIFO.
interface ibex_fetch_realign_fifo_if;
   logic        clear_i;
   logic [31:0] in_addr_i;
   logic        in_valid_i;
   logic [31:0] in_rdata_i;
   logic        in_err_i;
   logic        busy_o;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_addr_o;
   logic [31:0] out_rdata_o;
   logic        out_err_o;
   logic        out_err_plus2_o;

   modport slave (
      input  clear_i, in_addr_i, in_valid_i, in_rdata_i, in_err_i, out_ready_i,
      output busy_o, out_valid_o, out_addr_o, out_rdata_o, out_err_o, out_err_plus2_o
   );

   modport master (
      output clear_i, in_addr_i, in_valid_i, in_rdata_i, in_err_i, out_ready_i,
      input  busy_o, out_valid_o, out_addr_o, out_rdata_o, out_err_o, out_err_plus2_o
   );
endinterface

// File: rtl/ibex_fetch_realign_fifo.sv
// Fetch FIFO presenting halfword-realigned 16/32-bit instructions with PC and error tracking.
// Optional IBEX_FETCH_BYPASS_EN forwards the incoming fetch word to the output in the same cycle.
module ibex_fetch_realign_fifo
   import ibex_fetch_realign_fifo_pkg::*;
#(
   parameter int NUM_REQS = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   ibex_fetch_realign_fifo_if.slave   bus
);

   localparam int DEPTH       = NUM_REQS + 1;
   localparam int BUSY_THRESH = DEPTH - NUM_REQS + 1;

   fetch_entry_t     entry_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [31:0]      addr_q;
   logic             busy_q;

   fetch_entry_t     ext_ent [DEPTH+1];
   logic [DEPTH:0]   ext_val;
   fetch_entry_t     ent_d [DEPTH];
   logic [DEPTH-1:0] val_d;
   logic             busy_d;
   logic             placed;

   fetch_entry_t     e0, e1;
   logic             v0, v1;
   logic             push, pop, free, unaligned, compressed, out_valid, plus2_raw;

   assign push = bus.in_valid_i & ~bus.clear_i;

   // Stored entries followed by the incoming word in the first free slot.
   always_comb begin
      placed = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ext_ent[i] = entry_q[i];
         ext_val[i] = valid_q[i];
      end
      ext_ent[DEPTH] = '0;
      ext_val[DEPTH] = 1'b0;
      if (push) begin
         for (int i = 0; i <= DEPTH; i++) begin
            if (!ext_val[i] && !placed) begin
               ext_ent[i] = {bus.in_rdata_i, bus.in_err_i};
               ext_val[i] = 1'b1;
               placed     = 1'b1;
            end
         end
      end
   end

   always_comb begin
`ifdef IBEX_FETCH_BYPASS_EN
      e0 = ext_ent[0];
      v0 = ext_val[0];
      e1 = ext_ent[1];
      v1 = ext_val[1];
`else
      e0 = entry_q[0];
      v0 = valid_q[0];
      e1 = entry_q[1];
      v1 = valid_q[1];
`endif
   end

   assign unaligned  = addr_q[1];
   assign compressed = unaligned ? is_compressed(e0.rdata[17:16]) : is_compressed(e0.rdata[1:0]);
   // A faulting first half is reported at once rather than waiting for its second word.
   assign out_valid  = v0 & (~unaligned | compressed | v1 | e0.err);
   assign plus2_raw  = unaligned & ~compressed & v1 & e1.err;
   assign pop        = out_valid & bus.out_ready_i & ~bus.clear_i;
   assign free       = pop & (unaligned | ~compressed);

   assign bus.out_valid_o     = out_valid;
   assign bus.out_addr_o      = addr_q;
   assign bus.out_rdata_o     = unaligned ? {e1.rdata[15:0], e0.rdata[31:16]} : e0.rdata;
   assign bus.out_err_o       = v0 & (e0.err | plus2_raw);
   assign bus.out_err_plus2_o = v0 & ~e0.err & plus2_raw;
   assign bus.busy_o          = busy_q;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = free ? ext_ent[i+1] : ext_ent[i];
         val_d[i] = free ? ext_val[i+1] : ext_val[i];
      end
      if (bus.clear_i) val_d = '0;
      busy_d = $countones(val_d) >= BUSY_THRESH;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
         valid_q <= '0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         entry_q <= ent_d;
         valid_q <= val_d;
         busy_q  <= busy_d;
         if (bus.clear_i)
            addr_q <= {bus.in_addr_i[31:1], 1'b0};
         else if (pop)
            addr_q <= addr_q + (compressed ? 32'd2 : 32'd4);
      end
   end

   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(ext_val[DEPTH] && !free));

   a_out_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (out_valid && !bus.out_ready_i && !bus.clear_i) |=>
         (out_valid && $stable(addr_q) && $stable(bus.out_rdata_o[15:0]) &&
          $stable(bus.out_err_o) && $stable(bus.out_err_plus2_o) &&
          ($past(compressed) || ($past(unaligned) && !$past(v1)) ||
           $stable(bus.out_rdata_o[31:16]))));

endmodule
